mdio_phy_responder: RTL and testbench

MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

---
 rtl/mdio_phy_responder_if.sv | 21 ++
 rtl/mdio_phy_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mdio_phy_responder_if.sv
// MDIO pin and write-notification bundle between a station (master) and the PHY responder (slave).
interface mdio_phy_responder_if;
    logic        mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oe;
    logic        wr_pulse;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;

    modport master (
        output mdc, mdio_in,
        input  mdio_out, mdio_oe, wr_pulse, wr_addr, wr_data, frame_err
    );

    modport slave (
        input  mdc, mdio_in,
        output mdio_out, mdio_oe, wr_pulse, wr_addr, wr_data, frame_err
    );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: oversamples MDC/MDIO in the clk_100Mz domain and serves a 32x16 register file.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | counting preamble 1s; a 0 after a full preamble is ST[1]
// S_ST1      | expecting ST[0] = 1
// S_OP       | shifting the 2-bit opcode (10 read, 01 write)
// S_PHYAD    | shifting the 5-bit PHY address
// S_REGAD    | shifting the 5-bit register address; read data latched at end
// S_TA       | read: take the bus and drive 0; write: sample TA, expect 10
// S_RD_DATA  | driving D15..D0, then releasing the pad
// S_WR_DATA  | shifting 16 write data bits; commit requested after D0
// S_SKIP     | ignoring the rest of a frame not addressed to us or bad TA
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'h0C,
    parameter int          PREAMBLE_MIN = 32,
    parameter logic [15:0] ID1          = 16'h2000,
    parameter logic [15:0] ID2          = 16'h5C90
) (
    input  logic                clk_100Mz,
    input  logic                rst_n,
    mdio_phy_responder_if.slave mdio
);

    localparam int                PRE_W   = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PREAMBLE_MIN);

    typedef enum logic [3:0] {
        S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_RD_DATA, S_WR_DATA, S_SKIP
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic [4:0]       bit_cnt;
    logic             first_bit;
    logic             op_rd;
    logic [4:0]       phy_sr;
    logic [4:0]       regad_sr;
    logic [15:0]      rd_sr;
    logic [15:0]      wr_sr;
    logic             commit_req;
    logic [15:0]      regs [32];

    logic mdc_s1, mdc_s2, mdc_s3;
    logic mdio_s1, mdio_s2;
    logic mdc_rise;
    logic bit_in;
    logic [4:0]  regad_next;
    logic [15:0] reg_rd;

    always_ff @(posedge clk_100Mz or negedge rst_n) begin
        if (!rst_n) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_s3  <= 1'b0;
            mdio_s1 <= 1'b0;
            mdio_s2 <= 1'b0;
        end else begin
            mdc_s1  <= mdio.mdc;
            mdc_s2  <= mdc_s1;
            mdc_s3  <= mdc_s2;
            mdio_s1 <= mdio.mdio_in;
            mdio_s2 <= mdio_s1;
        end
    end

    assign mdc_rise   = mdc_s2 & ~mdc_s3;
    assign bit_in     = mdio_s2;
    assign regad_next = {regad_sr[3:0], bit_in};
    assign reg_rd     = regs[regad_next];

    always_ff @(posedge clk_100Mz or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pre_cnt        <= '0;
            bit_cnt        <= '0;
            first_bit      <= 1'b0;
            op_rd          <= 1'b0;
            phy_sr         <= '0;
            regad_sr       <= '0;
            rd_sr          <= '0;
            wr_sr          <= '0;
            commit_req     <= 1'b0;
            mdio.mdio_out  <= 1'b0;
            mdio.mdio_oe   <= 1'b0;
            mdio.frame_err <= 1'b0;
        end else begin
            mdio.frame_err <= 1'b0;
            commit_req     <= 1'b0;
            if (mdc_rise) begin
                case (state)
                    S_IDLE: begin
                        if (bit_in) begin
                            if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
                        end else begin
                            if (pre_cnt == PRE_MAX) state <= S_ST1;
                            pre_cnt <= '0;
                        end
                    end
                    S_ST1: begin
                        if (bit_in) begin
                            state   <= S_OP;
                            bit_cnt <= 5'd1;
                        end else begin
                            mdio.frame_err <= 1'b1;
                            state          <= S_IDLE;
                        end
                    end
                    S_OP: begin
                        first_bit <= bit_in;
                        if (bit_cnt != 5'd0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (first_bit == bit_in) begin
                            mdio.frame_err <= 1'b1;
                            state          <= S_IDLE;
                        end else begin
                            op_rd   <= first_bit;
                            state   <= S_PHYAD;
                            bit_cnt <= 5'd4;
                        end
                    end
                    S_PHYAD: begin
                        phy_sr <= {phy_sr[3:0], bit_in};
                        if (bit_cnt != 5'd0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else begin
                            state   <= S_REGAD;
                            bit_cnt <= 5'd4;
                        end
                    end
                    S_REGAD: begin
                        regad_sr <= regad_next;
                        if (bit_cnt != 5'd0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (phy_sr != PHY_ADDR) begin
                            // TA plus 16 data bits belong to another PHY
                            state   <= S_SKIP;
                            bit_cnt <= 5'd17;
                        end else begin
                            if (op_rd) rd_sr <= reg_rd;
                            state   <= S_TA;
                            bit_cnt <= 5'd1;
                        end
                    end
                    S_TA: begin
                        if (op_rd) begin
                            mdio.mdio_oe  <= 1'b1;
                            mdio.mdio_out <= 1'b0;
                            state         <= S_RD_DATA;
                            bit_cnt       <= 5'd16;
                        end else begin
                            first_bit <= bit_in;
                            if (bit_cnt != 5'd0) begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end else if ({first_bit, bit_in} == 2'b10) begin
                                state   <= S_WR_DATA;
                                bit_cnt <= 5'd15;
                            end else begin
                                mdio.frame_err <= 1'b1;
                                state          <= S_SKIP;
                                bit_cnt        <= 5'd15;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (bit_cnt != 5'd0) begin
                            mdio.mdio_out <= rd_sr[15];
                            rd_sr         <= {rd_sr[14:0], 1'b0};
                            bit_cnt       <= bit_cnt - 1'b1;
                        end else begin
                            mdio.mdio_oe  <= 1'b0;
                            mdio.mdio_out <= 1'b0;
                            state         <= S_IDLE;
                        end
                    end
                    S_WR_DATA: begin
                        wr_sr <= {wr_sr[14:0], bit_in};
                        if (bit_cnt != 5'd0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end else begin
                            commit_req <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                    S_SKIP: begin
                        if (bit_cnt != 5'd0) bit_cnt <= bit_cnt - 1'b1;
                        else                 state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    function automatic logic [15:0] reg_init(input int idx);
        if (idx == 2) return ID1;
        if (idx == 3) return ID2;
        return 16'h0000;
    endfunction

    // Registers 2/3 are never written, so they keep their ID values from reset.
    always_ff @(posedge clk_100Mz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i[4:0]] <= reg_init(i);
            mdio.wr_pulse <= 1'b0;
            mdio.wr_addr  <= '0;
            mdio.wr_data  <= '0;
        end else begin
            mdio.wr_pulse <= commit_req;
            if (commit_req) begin
                mdio.wr_addr <= regad_sr;
                mdio.wr_data <= wr_sr;
                if (regad_sr == 5'd0 && wr_sr[15]) begin
                    for (int i = 0; i < 32; i++) regs[i[4:0]] <= reg_init(i);
                end else if (regad_sr != 5'd2 && regad_sr != 5'd3) begin
                    regs[regad_sr] <= wr_sr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed and randomized MDIO frames against a register-level reference model.
module tb_mdio_phy_responder;

    localparam logic [4:0]  PHY = 5'h0C;
    localparam logic [15:0] ID1 = 16'h2000;
    localparam logic [15:0] ID2 = 16'h5C90;

    logic clk_100Mz = 1'b0;
    logic rst_n     = 1'b0;
    always #5 clk_100Mz = ~clk_100Mz;

    mdio_phy_responder_if bus ();

    mdio_phy_responder #(
        .PHY_ADDR(PHY), .PREAMBLE_MIN(32), .ID1(ID1), .ID2(ID2)
    ) dut (
        .clk_100Mz(clk_100Mz),
        .rst_n    (rst_n),
        .mdio     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    logic [4:0]  last_wa = '0;
    logic [15:0] last_wd = '0;
    logic [15:0] model [32];

    always @(negedge clk_100Mz) begin
        if (bus.wr_pulse === 1'b1) begin
            wr_cnt++;
            last_wa = bus.wr_addr;
            last_wd = bus.wr_data;
        end
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 16'h0000;
        model[2] = ID1;
        model[3] = ID2;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd0 && d[15]) model_reset();
        else if (a != 5'd2 && a != 5'd3) model[a] = d;
    endtask

    task automatic mdc_bit(input logic b, output logic oe_s, output logic out_s);
        @(posedge clk_100Mz); #1 bus.mdio_in = b;
        repeat (5) @(posedge clk_100Mz);
        #1 bus.mdc = 1'b1;
        repeat (6) @(posedge clk_100Mz);
        #1;
        oe_s    = bus.mdio_oe;
        out_s   = bus.mdio_out;
        bus.mdc = 1'b0;
    endtask

    // vector bit 31 holds the sample after the first post-preamble edge
    task automatic run_frame(input int npre, input logic [31:0] bits, input int nbits,
                             output logic [31:0] oe_v, output logic [31:0] out_v);
        logic o, d;
        oe_v  = '0;
        out_v = '0;
        for (int i = 0; i < npre; i++) mdc_bit(1'b1, o, d);
        for (int i = 0; i < nbits; i++) begin
            mdc_bit(bits[31-i], o, d);
            oe_v[31-i]  = o;
            out_v[31-i] = d;
        end
    endtask

    task automatic frame_check(input string tag, input int npre, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] regad,
                               input logic [1:0] ta, input logic [15:0] data);
        logic [31:0] oe_v, out_v, exp_oe, exp_out;
        int w0, e0;
        bit started, match, is_wr, is_rd, exp_err;
        w0 = wr_cnt;
        e0 = err_cnt;
        run_frame(npre, {2'b01, op, phy, regad, ta, data}, 32, oe_v, out_v);
        repeat (4) @(posedge clk_100Mz);
        #1;
        started = (npre >= 32);
        match   = (phy == PHY);
        is_rd   = started && op == 2'b10 && match;
        is_wr   = started && op == 2'b01 && match && ta == 2'b10;
        exp_err = started && ((op == 2'b00 || op == 2'b11) ||
                              (op == 2'b01 && match && ta != 2'b10));
        exp_oe  = is_rd ? 32'h0003_FFFE : 32'h0;
        exp_out = is_rd ? {15'b0, model[regad], 1'b0} : 32'h0;
        check({tag, "_oe"},  oe_v,  exp_oe);
        check({tag, "_out"}, out_v, exp_out);
        check({tag, "_wr_pulses"}, 32'(wr_cnt - w0), is_wr ? 32'd1 : 32'd0);
        check({tag, "_frame_errs"}, 32'(err_cnt - e0), exp_err ? 32'd1 : 32'd0);
        if (is_wr) begin
            check({tag, "_wr_addr"}, 32'(last_wa), 32'(regad));
            check({tag, "_wr_data"}, 32'(last_wd), 32'(data));
            model_write(regad, data);
        end
    endtask

    initial begin
        logic [31:0] oe_v, out_v;
        logic [1:0]  op, ta;
        logic [4:0]  phy, ra;
        logic [15:0] dat;

        bus.mdc     = 1'b0;
        bus.mdio_in = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_100Mz);
        #1;
        check("rst_oe",        32'(bus.mdio_oe),   32'd0);
        check("rst_out",       32'(bus.mdio_out),  32'd0);
        check("rst_wr_pulse",  32'(bus.wr_pulse),  32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
        check("rst_wr_data",   32'(bus.wr_data),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_100Mz);

        frame_check("w04",      32, 2'b01, PHY, 5'h04, 2'b10, 16'hA5C3);
        frame_check("r04",      32, 2'b10, PHY, 5'h04, 2'b11, 16'hFFFF);
        frame_check("r02",      32, 2'b10, PHY, 5'h02, 2'b11, 16'hFFFF);
        frame_check("r03",      32, 2'b10, PHY, 5'h03, 2'b11, 16'hFFFF);
        frame_check("w02",      32, 2'b01, PHY, 5'h02, 2'b10, 16'hFFFF);
        frame_check("r02_ro",   32, 2'b10, PHY, 5'h02, 2'b11, 16'hFFFF);
        frame_check("w05_phy0d",32, 2'b01, 5'h0D, 5'h05, 2'b10, 16'h1234);
        frame_check("w05",      32, 2'b01, PHY, 5'h05, 2'b10, 16'h5678);
        frame_check("pre31",    31, 2'b01, PHY, 5'h05, 2'b10, 16'hDEAD);
        frame_check("r05_a",    32, 2'b10, PHY, 5'h05, 2'b11, 16'hFFFF);
        frame_check("op11",     32, 2'b11, PHY, 5'h05, 2'b10, 16'h0F0F);
        frame_check("ta11",     32, 2'b01, PHY, 5'h05, 2'b11, 16'hBEEF);
        frame_check("r05_b",    32, 2'b10, PHY, 5'h05, 2'b11, 16'hFFFF);

        // reset while D8 of reg4 is on the pin
        run_frame(32, {2'b01, 2'b10, PHY, 5'h04, 2'b11, 16'hFFFF}, 23, oe_v, out_v);
        check("abort_oe_before", 32'(bus.mdio_oe), 32'd1);
        check("abort_d8",        32'(bus.mdio_out), 32'(model[4][8]));
        #2 rst_n = 1'b0;
        #1;
        check("abort_oe_async", 32'(bus.mdio_oe), 32'd0);
        model_reset();
        repeat (3) @(posedge clk_100Mz);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk_100Mz);
        frame_check("post_rst_r04", 32, 2'b10, PHY, 5'h04, 2'b11, 16'hFFFF);
        frame_check("post_rst_w07", 32, 2'b01, PHY, 5'h07, 2'b10, 16'h3C3C);
        frame_check("post_rst_r07", 32, 2'b10, PHY, 5'h07, 2'b11, 16'hFFFF);

        frame_check("w09",      32, 2'b01, PHY, 5'h09, 2'b10, 16'h4242);
        frame_check("w00_rst",  32, 2'b01, PHY, 5'h00, 2'b10, 16'h8000);
        frame_check("r09_sr",   32, 2'b10, PHY, 5'h09, 2'b11, 16'hFFFF);
        frame_check("r00_sr",   32, 2'b10, PHY, 5'h00, 2'b11, 16'hFFFF);
        frame_check("r03_sr",   32, 2'b10, PHY, 5'h03, 2'b11, 16'hFFFF);

        for (int k = 0; k < 16; k++) begin
            op  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                              : ($urandom_range(0, 1) == 0 ? 2'b01 : 2'b10);
            phy = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : PHY;
            ra  = 5'($urandom_range(0, 15));
            ta  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            dat = 16'($urandom);
            frame_check($sformatf("rnd%0d", k), 32 + int'($urandom_range(0, 3)),
                        op, phy, ra, ta, dat);
        end
        for (int k = 0; k < 4; k++)
            frame_check($sformatf("rnd_rb%0d", k), 32, 2'b10, PHY, 5'($urandom_range(0, 15)),
                        2'b11, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
